// File: rtl/uart_pkg.sv
// Purpose  : shared definitions for the UART receive path (state encoding, frame constants).
// Latency  : n/a (package only).
// Backpress: n/a.
package uart_pkg;

   // 100 MHz core clock at 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   // 8N1 frame: one start bit, DATA_BITS data bits LSB first, one stop bit.
   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose  : two-flop synchroniser for a single asynchronous input, reset to a chosen level.
// Latency  : 2 clock cycles from d to q.
// Backpress: none; free-running.
// Ports    : clock, reset (sync, active high), d (async in), q (synchronised out).
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_control.sv
// Purpose  : 8N1 UART receiver with enable gating; mid-bit sampling, break suppression.
// Latency  : data_valid is visible HALF + 9*CLKS_PER_BIT + 1 cycles after the first gated-low cycle.
// Backpress: none; consumer must capture data_out on the data_valid cycle.
// Ports    : clock, reset (sync, active high), enable_uart, rx_in (async line, idle high),
//            data_out[7:0] (last good byte), data_valid / frame_error (1-cycle pulses), busy.
module uart_rx_control
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable_uart,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam int              CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]   BIT_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

   logic rx_s;
   logic rx_g;

   rx_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shreg_q, shreg_d;
   logic [7:0]     data_d;
   logic           valid_d;
   logic           ferr_d;

   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_sync_rx (
      .clock (clock),
      .reset (reset),
      .d     (rx_in),
      .q     (rx_s)
   );

   // A disabled receiver sees a permanently idle line.
   assign rx_g = enable_uart ? rx_s : 1'b1;

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         data_out    <= data_d;
         data_valid  <= valid_d;
         frame_error <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_out;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      if (!enable_uart) begin
         // Abort silently: no pulse for a frame cut short by disable.
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               idx_d = '0;
               if (!rx_g) begin
                  state_d = ST_START;
               end
            end

            ST_START: begin
               // Re-check the start bit at its centre; a high line here was a glitch.
               if (cnt_q == HALF_M1) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_g ? ST_IDLE : ST_DATA;
               end
            end

            ST_DATA: begin
               if (cnt_q == BIT_M1) begin
                  cnt_d          = '0;
                  shreg_d[idx_q] = rx_g;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end

            ST_STOP: begin
               if (cnt_q == BIT_M1) begin
                  cnt_d = '0;
                  if (rx_g) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_BREAK;
                  end
               end
            end

            ST_BREAK: begin
               // Hold here while the line stays low so a break is not read as 0x00 frames.
               cnt_d = '0;
               if (rx_g) begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_control.sv
// Purpose  : self-checking bench for uart_rx_control with a timestamp-based frame model.
// Latency  : n/a.
// Backpress: n/a.
module tb_uart_rx_control;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable_uart = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       busy;

   uart_rx_control #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable_uart (enable_uart),
      .rx_in       (rx_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: line history plus the frame start timestamp; every sample
   // instant is derived arithmetically from that timestamp.
   int         cyc = 0;
   int         m_mode = 0;      // 0 idle, 1 in frame, 2 waiting out a break
   int         m_e0 = 0;
   logic [7:0] m_bits = '0;
   logic [7:0] m_dout = '0;
   logic       m_dv = 1'b0;
   logic       m_fe = 1'b0;
   logic       h1 = 1'b1;
   logic       h2 = 1'b1;

   int         dv_cnt = 0;
   int         fe_cnt = 0;
   int         last_dv_cyc = -1;
   logic [7:0] dv_vals[$];
   int         last_start = 0;

   always begin : monitor
      logic g;
      int   off;
      int   j;
      @(posedge clock);
      cyc++;
      if (reset) begin
         m_mode = 0;
         m_dout = '0;
         m_dv   = 1'b0;
         m_fe   = 1'b0;
         h1     = 1'b1;
         h2     = 1'b1;
      end else begin
         m_dv = 1'b0;
         m_fe = 1'b0;
         g    = enable_uart ? h2 : 1'b1;
         if (!enable_uart) begin
            m_mode = 0;
         end else if (m_mode == 0) begin
            if (!g) begin
               m_mode = 1;
               m_e0   = cyc;
            end
         end else if (m_mode == 1) begin
            off = cyc - m_e0;
            if (off == HALF) begin
               if (g) m_mode = 0;
            end else if (off > HALF && (off - HALF) % CPB == 0) begin
               j = (off - HALF) / CPB - 1;
               if (j < 8) begin
                  m_bits[j[2:0]] = g;
               end else if (g) begin
                  m_dv   = 1'b1;
                  m_dout = m_bits;
                  m_mode = 0;
               end else begin
                  m_fe   = 1'b1;
                  m_mode = 2;
               end
            end
         end else if (g) begin
            m_mode = 0;
         end
         h2 = h1;
         h1 = rx_in;
      end
      #1;
      check($sformatf("outputs@%0d {dv,fe,busy,data}", cyc),
            {21'd0, data_valid, frame_error, busy, data_out},
            {21'd0, m_dv, m_fe, (m_mode != 0), m_dout});
      if (data_valid) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         dv_vals.push_back(data_out);
      end
      if (frame_error) fe_cnt++;
   end

   task automatic hold(input logic v, input int n);
      rx_in = v;
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   // Drive one frame at clks cycles per bit. drop_at / rst_at (bit-cycle offsets,
   // -1 for none) drop enable or pulse reset part way through.
   task automatic send(input logic [7:0] b, input int clks, input logic stop_v,
                       input int drop_at, input int rst_at);
      logic [9:0] fr;
      fr = {stop_v, b, 1'b0};
      last_start = cyc + 1;
      for (int i = 0; i < 10 * clks; i++) begin
         rx_in = fr[i / clks];
         if (i == drop_at) enable_uart = 1'b0;
         if (i == rst_at) reset = 1'b1;
         @(posedge clock);
         #2;
         if (i == drop_at) check("busy after disable", {31'd0, busy}, 32'd0);
         if (i == rst_at) begin
            check("reset data_out", {24'd0, data_out}, 32'd0);
            check("reset pulses/busy", {29'd0, data_valid, frame_error, busy}, 32'd0);
            reset = 1'b0;
            rx_in = 1'b1;
            break;
         end
      end
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int d0, f0, s;
      logic [7:0] b;
      int kind;
      int clks;

      repeat (3) begin
         @(posedge clock);
         #2;
      end
      check("reset data_out", {24'd0, data_out}, 32'd0);
      check("reset dv/fe/busy", {29'd0, data_valid, frame_error, busy}, 32'd0);
      reset = 1'b0;
      hold(1'b1, 5);

      // Single byte, exact pulse timing.
      d0 = dv_cnt; f0 = fe_cnt;
      send(8'hA5, 16, 1'b1, -1, -1);
      hold(1'b1, 10);
      check("A5 pulse count", dv_cnt - d0, 1);
      check("A5 value", {24'd0, dv_vals[$]}, 32'hA5);
      check("A5 pulse cycle", last_dv_cyc, last_start + 2 + HALF + 9 * CPB);
      check("A5 no frame error", fe_cnt - f0, 0);
      check("A5 model data", {24'd0, m_dout}, 32'hA5);

      // Back-to-back with no idle gap.
      d0 = dv_cnt;
      send(8'h00, 16, 1'b1, -1, -1);
      send(8'hFF, 16, 1'b1, -1, -1);
      hold(1'b1, 10);
      check("b2b pulse count", dv_cnt - d0, 2);
      check("b2b first", {24'd0, dv_vals[dv_vals.size() - 2]}, 32'h00);
      check("b2b second", {24'd0, dv_vals[dv_vals.size() - 1]}, 32'hFF);

      // Framing error then break.
      d0 = dv_cnt; f0 = fe_cnt;
      send(8'h3C, 16, 1'b0, -1, -1);
      hold(1'b0, 40);
      check("ferr pulse count", fe_cnt - f0, 1);
      check("ferr no valid", dv_cnt - d0, 0);
      check("ferr data held", {24'd0, data_out}, 32'hFF);
      check("break busy", {31'd0, busy}, 32'd1);
      hold(1'b1, 5);
      check("break released", {31'd0, busy}, 32'd0);
      send(8'h55, 16, 1'b1, -1, -1);
      hold(1'b1, 10);
      check("after break count", dv_cnt - d0, 1);
      check("after break value", {24'd0, dv_vals[$]}, 32'h55);

      // Short glitch on an idle line.
      d0 = dv_cnt; f0 = fe_cnt;
      s = cyc + 1;
      hold(1'b0, 3);
      hold(1'b1, 7);
      check("glitch busy before start check", {31'd0, busy}, 32'd1);
      check("glitch cycle", cyc, s + 9);
      hold(1'b1, 1);
      check("glitch busy after start check", {31'd0, busy}, 32'd0);
      hold(1'b1, 20);
      check("glitch no pulses", (dv_cnt - d0) + (fe_cnt - f0), 0);

      // Enable dropped during bit 4.
      d0 = dv_cnt; f0 = fe_cnt;
      send(8'h81, 16, 1'b1, 5 * 16 + 5, -1);
      hold(1'b1, 10);
      check("disable no pulses", (dv_cnt - d0) + (fe_cnt - f0), 0);
      enable_uart = 1'b1;
      hold(1'b1, 5);
      send(8'h7E, 16, 1'b1, -1, -1);
      hold(1'b1, 10);
      check("reenable count", dv_cnt - d0, 1);
      check("reenable value", {24'd0, dv_vals[$]}, 32'h7E);

      // Reset mid-frame, then off-rate senders.
      d0 = dv_cnt;
      send(8'h5A, 16, 1'b1, -1, 70);
      hold(1'b1, 20);
      check("reset abort no pulse", dv_cnt - d0, 0);
      send(8'hC3, 17, 1'b1, -1, -1);
      hold(1'b1, 20);
      check("17clk count", dv_cnt - d0, 1);
      check("17clk value", {24'd0, dv_vals[$]}, 32'hC3);
      send(8'hC3, 15, 1'b1, -1, -1);
      hold(1'b1, 30);
      check("15clk count", dv_cnt - d0, 2);
      check("15clk value", {24'd0, dv_vals[$]}, 32'hC3);

      // Random traffic against the model.
      for (int n = 0; n < 40; n++) begin
         b    = 8'($urandom);
         kind = int'($urandom_range(0, 9));
         clks = int'($urandom_range(15, 17));
         case (kind)
            0: begin
               send(b, clks, 1'b0, -1, -1);
               hold(1'b0, int'($urandom_range(0, 30)));
            end
            1: begin
               send(b, clks, 1'b1, int'($urandom_range(0, 10 * clks - 1)), -1);
               hold(1'b1, 5);
               enable_uart = 1'b1;
            end
            2: hold(1'b0, int'($urandom_range(1, 6)));
            default: send(b, clks, 1'b1, -1, -1);
         endcase
         hold(1'b1, int'($urandom_range(0, 12)));
      end

      hold(1'b1, 50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
